// File: rtl/arm_defs_pkg.sv
// Shared ARM decode definitions.
// Holds the ALU command codes, data-processing opcodes, instruction mode
// encodings, condition codes, the architectural register count and the
// condition evaluation helper used by the decode stage.
package arm_defs_pkg;

    localparam int NUM_REGS = 15;

    // ALU commands driven on exe_cmd
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Data-processing opcodes, instruction[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Instruction modes, instruction[27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Condition codes, instruction[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv is {N,Z,C,V}; the reserved code 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file R0..R14 with two combinational read ports and
// one write port. Index 15 reads back pc_in; writes to index 15 are dropped.
// Asynchronous reset loads each register with its own index.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward the write-port
// data to a read port addressing the same register in the same cycle.
// Ports:
//   clk, rst            clock, async active-high reset
//   rd_idx1, rd_idx2    read indices
//   pc_in               value returned for index 15
//   we, wr_idx, wr_data write port
//   rd_data1, rd_data2  read data
module register_file
    import arm_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        rd_idx1,
    input  logic [3:0]        rd_idx2,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              we,
    input  logic [3:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = we && (wr_idx != 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (wr_ok) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        if (rd_idx1 == 4'd15) begin
            rd_data1 = pc_in;
`ifdef REGFILE_WRITE_BYPASS_EN
        end else if (wr_ok && (wr_idx == rd_idx1)) begin
            rd_data1 = wr_data;
`endif
        end else begin
            rd_data1 = regs[rd_idx1];
        end
    end

    always_comb begin
        if (rd_idx2 == 4'd15) begin
            rd_data2 = pc_in;
`ifdef REGFILE_WRITE_BYPASS_EN
        end else if (wr_ok && (wr_idx == rd_idx2)) begin
            rd_data2 = wr_data;
`endif
        end else begin
            rd_data2 = regs[rd_idx2];
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// ARM decode stage feeding the ID/EX register: decodes data-processing,
// load/store and branch formats, evaluates the condition field against NZCV,
// reads the register file and inserts a bubble on a failed condition or a
// hazard stall. Optional feature: REGFILE_WRITE_BYPASS_EN (see register_file).
// Ports:
//   clk, rst                        clock, async active-high reset
//   instruction, pc_in, sr, hazard  IF/ID inputs, status flags, stall request
//   wb_wb_en, wb_dest, wb_value     write-back port
//   wb_en mem_r_en mem_w_en b s     decoded controls (zeroed in a bubble)
//   exe_cmd                         ALU command (zeroed in a bubble)
//   pc val_rn val_rm imm shift_operand signed_imm_24 dest sr_out
//                                   data fields for the ID/EX register
//   src1 src2 two_src               source indices for the hazard unit
module instruction_decode_stage
    import arm_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        sr,
    input  logic              hazard,
    input  logic              wb_wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic [3:0]        sr_out,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src
);

    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;

    logic       raw_wb_en;
    logic       raw_mem_r_en;
    logic       raw_mem_w_en;
    logic       raw_b;
    logic       raw_s;
    logic [3:0] raw_exe_cmd;
    logic       bubble;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn     = instruction[19:16];
    assign rd     = instruction[15:12];
    assign rm     = instruction[3:0];

    always_comb begin
        raw_wb_en    = 1'b0;
        raw_mem_r_en = 1'b0;
        raw_mem_w_en = 1'b0;
        raw_b        = 1'b0;
        raw_s        = 1'b0;
        raw_exe_cmd  = EXE_NOP;
        case (mode)
            MODE_DP: begin
                raw_wb_en = 1'b1;
                raw_s     = s_bit;
                case (opcode)
                    OP_MOV: raw_exe_cmd = EXE_MOV;
                    OP_MVN: raw_exe_cmd = EXE_MVN;
                    OP_ADD: raw_exe_cmd = EXE_ADD;
                    OP_ADC: raw_exe_cmd = EXE_ADC;
                    OP_SUB: raw_exe_cmd = EXE_SUB;
                    OP_SBC: raw_exe_cmd = EXE_SBC;
                    OP_AND: raw_exe_cmd = EXE_AND;
                    OP_ORR: raw_exe_cmd = EXE_ORR;
                    OP_EOR: raw_exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        raw_exe_cmd = EXE_SUB;
                        raw_wb_en   = 1'b0;
                    end
                    OP_TST: begin
                        raw_exe_cmd = EXE_AND;
                        raw_wb_en   = 1'b0;
                    end
                    default: begin
                        raw_wb_en = 1'b0;
                        raw_s     = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                raw_exe_cmd = EXE_ADD;
                if (s_bit) begin
                    raw_mem_r_en = 1'b1;
                    raw_wb_en    = 1'b1;
                end else begin
                    raw_mem_w_en = 1'b1;
                end
            end
            MODE_BR: begin
                raw_b = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bubble = hazard | ~cond_pass(cond, sr);

    assign wb_en    = raw_wb_en    & ~bubble;
    assign mem_r_en = raw_mem_r_en & ~bubble;
    assign mem_w_en = raw_mem_w_en & ~bubble;
    assign b        = raw_b        & ~bubble;
    assign s        = raw_s        & ~bubble;
    assign exe_cmd  = bubble ? EXE_NOP : raw_exe_cmd;

    // Source indices are index outputs and so ignore the bubble: the hazard
    // unit must still see that a stalled STR reads Rd.
    assign src1    = rn;
    assign src2    = raw_mem_w_en ? rd : rm;
    assign two_src = ~instruction[25] | raw_mem_w_en;

    assign pc            = pc_in;
    assign imm           = instruction[25];
    assign shift_operand = instruction[11:0];
    assign signed_imm_24 = instruction[23:0];
    assign dest          = rd;
    assign sr_out        = sr;

    // Second read port follows src2 so a store carries its data in val_rm.
    register_file #(
        .DATA_W (DATA_W)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rd_idx1  (src1),
        .rd_idx2  (src2),
        .pc_in    (pc_in),
        .we       (wb_wb_en),
        .wr_idx   (wb_dest),
        .wr_data  (wb_value),
        .rd_data1 (val_rn),
        .rd_data2 (val_rm)
    );

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic [3:0]  sr;
    logic        hazard;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic [31:0] pc, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, sr_out, src1, src2;
    logic        two_src;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic        wb_en, mem_r_en, mem_w_en, b, s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc, val_rn, val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest, sr_out, src1, src2;
        logic        two_src;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_regs [15];

    always #5 clk = ~clk;

    instruction_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .pc_in         (pc_in),
        .sr            (sr),
        .hazard        (hazard),
        .wb_wb_en      (wb_wb_en),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value),
        .wb_en         (wb_en),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .b             (b),
        .s             (s),
        .exe_cmd       (exe_cmd),
        .pc            (pc),
        .val_rn        (val_rn),
        .val_rm        (val_rm),
        .imm           (imm),
        .shift_operand (shift_operand),
        .signed_imm_24 (signed_imm_24),
        .dest          (dest),
        .sr_out        (sr_out),
        .src1          (src1),
        .src2          (src2),
        .two_src       (two_src)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [3:0] idx, input logic [31:0] pcv,
                                             input logic we, input logic [3:0] wd,
                                             input logic [31:0] wv);
        if (idx == 4'd15) return pcv;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && wd == idx) return wv;
`endif
        return ref_regs[idx];
    endfunction

    task automatic chk(input string name, input string tag, input logic [31:0] act,
                       input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, expv);
        end
    endtask

    // One vector per clock: inputs applied just after a rising edge, expected
    // response queued, register model updated after the following edge.
    task automatic drive(input string tag, input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [3:0] srv, input logic hz, input logic we,
                         input logic [3:0] wd, input logic [31:0] wv, input logic rst_v);
        exp_t  e;
        logic [1:0] mode = ins[27:26];
        logic [3:0] op   = ins[24:21];
        bit    is_str;
        bit    pass;
        if (rst_v) begin
            for (int i = 0; i < 15; i++) ref_regs[i] = i;
        end
        e.wb_en = 0; e.mem_r_en = 0; e.mem_w_en = 0; e.b = 0; e.s = 0; e.exe_cmd = 0;
        if (mode == 2'b00) begin
            case (op)
                4'b1101: e.exe_cmd = 4'd1;
                4'b1111: e.exe_cmd = 4'd9;
                4'b0100: e.exe_cmd = 4'd2;
                4'b0101: e.exe_cmd = 4'd3;
                4'b0010: e.exe_cmd = 4'd4;
                4'b0110: e.exe_cmd = 4'd5;
                4'b0000: e.exe_cmd = 4'd6;
                4'b1100: e.exe_cmd = 4'd7;
                4'b0001: e.exe_cmd = 4'd8;
                4'b1010: e.exe_cmd = 4'd4;
                4'b1000: e.exe_cmd = 4'd6;
                default: e.exe_cmd = 4'd0;
            endcase
            if (e.exe_cmd != 0) begin
                e.s     = ins[20];
                e.wb_en = !(op == 4'b1010 || op == 4'b1000);
            end
        end else if (mode == 2'b01) begin
            e.exe_cmd  = 4'd2;
            e.mem_r_en = ins[20];
            e.wb_en    = ins[20];
            e.mem_w_en = !ins[20];
        end else if (mode == 2'b10) begin
            e.b = 1;
        end
        is_str    = (mode == 2'b01) && !ins[20];
        e.src1    = ins[19:16];
        e.src2    = is_str ? ins[15:12] : ins[3:0];
        e.two_src = !ins[25] || is_str;
        pass = ref_cond(ins[31:28], srv) && !hz;
        if (!pass) begin
            e.wb_en = 0; e.mem_r_en = 0; e.mem_w_en = 0; e.b = 0; e.s = 0; e.exe_cmd = 0;
        end
        e.pc            = pcv;
        e.val_rn        = ref_read(e.src1, pcv, we, wd, wv);
        e.val_rm        = ref_read(e.src2, pcv, we, wd, wv);
        e.imm           = ins[25];
        e.shift_operand = ins[11:0];
        e.signed_imm_24 = ins[23:0];
        e.dest          = ins[15:12];
        e.sr_out        = srv;
        e.tag           = tag;
        exp_q.push_back(e);

        rst = rst_v; instruction = ins; pc_in = pcv; sr = srv; hazard = hz;
        wb_wb_en = we; wb_dest = wd; wb_value = wv;

        @(posedge clk);
        if (!rst_v && we && wd != 4'd15) ref_regs[wd] = wv;
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_en",     e.tag, 32'(wb_en),         32'(e.wb_en));
                chk("mem_r_en",  e.tag, 32'(mem_r_en),      32'(e.mem_r_en));
                chk("mem_w_en",  e.tag, 32'(mem_w_en),      32'(e.mem_w_en));
                chk("b",         e.tag, 32'(b),             32'(e.b));
                chk("s",         e.tag, 32'(s),             32'(e.s));
                chk("exe_cmd",   e.tag, 32'(exe_cmd),       32'(e.exe_cmd));
                chk("pc",        e.tag, pc,                 e.pc);
                chk("val_rn",    e.tag, val_rn,             e.val_rn);
                chk("val_rm",    e.tag, val_rm,             e.val_rm);
                chk("imm",       e.tag, 32'(imm),           32'(e.imm));
                chk("shift_op",  e.tag, 32'(shift_operand), 32'(e.shift_operand));
                chk("simm24",    e.tag, 32'(signed_imm_24), 32'(e.signed_imm_24));
                chk("dest",      e.tag, 32'(dest),          32'(e.dest));
                chk("sr_out",    e.tag, 32'(sr_out),        32'(e.sr_out));
                chk("src1",      e.tag, 32'(src1),          32'(e.src1));
                chk("src2",      e.tag, 32'(src2),          32'(e.src2));
                chk("two_src",   e.tag, 32'(two_src),       32'(e.two_src));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ins;
        logic [3:0]  c4;
        rst = 1'b1; instruction = 32'h0; pc_in = 32'h0; sr = 4'h0; hazard = 1'b0;
        wb_wb_en = 1'b0; wb_dest = 4'h0; wb_value = 32'h0;
        for (int i = 0; i < 15; i++) ref_regs[i] = i;
        repeat (3) @(posedge clk);
        #1;

        // reset values, PC read through index 15
        drive("rst_r3_r7", 32'hE1830007, 32'h0, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        drive("rn_pc",     32'hE08F1003, 32'h40, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        for (int i = 0; i < 15; i += 2) begin
            ins = 32'hE0800000 | (32'(i) << 16) | 32'(i + 1);
            drive("reset_read", ins, 32'h100, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        end
        // data processing, conditional CMP
        drive("add",       32'hE0821003, 32'h44, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        drive("cmpeq_z0",  32'h01500002, 32'h48, 4'b0000, 0, 0, 4'h0, 32'h0, 0);
        drive("cmpeq_z1",  32'h01500002, 32'h48, 4'b0100, 0, 0, 4'h0, 32'h0, 0);
        drive("cond_nv",   32'hF0821003, 32'h4C, 4'b1111, 0, 0, 4'h0, 32'h0, 0);
        // store, then the same store stalled
        drive("str",       32'hE5812000, 32'h50, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        drive("str_haz",   32'hE5812000, 32'h50, 4'h0, 1, 0, 4'h0, 32'h0, 0);
        drive("ldr",       32'hE5912004, 32'h54, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        drive("branch",    32'hEA00000F, 32'h58, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        drive("mode11",    32'hEC821003, 32'h5C, 4'h0, 0, 0, 4'h0, 32'h0, 0);
        // write R5 while reading it, then read after the edge
        drive("wr_r5",     32'hE0851005, 32'h60, 4'h0, 0, 1, 4'd5, 32'hDEADBEEF, 0);
        drive("rd_r5",     32'hE0851005, 32'h60, 4'h0, 0, 0, 4'd5, 32'h0, 0);
        // write to index 15 is dropped
        drive("wr_r15",    32'hE08F100E, 32'h64, 4'h0, 0, 1, 4'd15, 32'h12345678, 0);
        drive("rd_r14",    32'hE08E100E, 32'h68, 4'h0, 0, 0, 4'd0, 32'h0, 0);
        // several writes, then async reset mid-run with a write that is lost
        drive("wr_r1",     32'hE0821003, 32'h70, 4'h0, 0, 1, 4'd1, 32'hA5A5A5A5, 0);
        drive("wr_r2",     32'hE0811002, 32'h74, 4'h0, 0, 1, 4'd2, 32'h5A5A5A5A, 0);
        drive("rst_mid",   32'hE0811002, 32'h78, 4'h0, 0, 1, 4'd5, 32'hCAFEF00D, 1);
        drive("after_rst", 32'hE0851002, 32'h7C, 4'h0, 0, 0, 4'd0, 32'h0, 0);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            ins = $urandom;
            c4  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            ins[31:28] = c4;
            drive("random", ins, $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)), $urandom, 0);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
